adc_frame_buffer: RTL and testbench
===================================

// Module: adc_frame_buffer
// PURPOSE
//  Downstream of the ADC SPI receiver: captures each DV-qualified 14-bit ADC sample,
//  converts it to signed two's complement and stores it in a ping-pong (2-bank) RAM.
//  When a bank holds FRAME_LEN samples it is handed to the FFT core, which reads it
//  by address and releases it with FRAME_DONE while the other bank keeps filling.
// PARAMETERS
//  DATA_W        14   sample width (matches ADC SPI DATA_OUT)
//  FRAME_LEN     64   samples per frame; power of two, >= 4
//  ADDR_W        6    log2(FRAME_LEN)
//  OFFSET_BIN    1    1: input is offset binary, invert MSB; 0: pass through unchanged
// PORTS
//  CLOCK        in   1        16 MHz system clock
//  RESET_N      in   1        asynchronous active-low reset
//  DV           in   1        sample valid, single-cycle pulse from ADC SPI
//  DATA_IN      in   DATA_W   ADC sample, valid when DV=1
//  FRAME_READY  out  1        a full bank is available to the FFT
//  FRAME_BANK   out  1        index of the bank being presented
//  RD_ADDR      in   ADDR_W   FFT read address within presented bank
//  RD_DATA      out  DATA_W   signed sample, registered
//  FRAME_DONE   in   1        FFT releases presented bank (1-cycle pulse)
//  OVERRUN      out  1        sticky: sample dropped because both banks full
//  OVERRUN_CLR  in   1        clears OVERRUN
// BEHAVIOUR
//  Reset: FRAME_READY=0, FRAME_BANK=0, RD_DATA=0, OVERRUN=0; write bank=0, write
//   index=0, both banks EMPTY. Reset mid-frame discards all stored samples.
//  Per-bank state: EMPTY -> FILLING (first write) -> FULL (write of index FRAME_LEN-1)
//   -> EMPTY (FRAME_DONE while presented). No other transitions.
//  Write path: on DV=1 with write bank not FULL, store conv(DATA_IN) at write index,
//   index++. Write of index FRAME_LEN-1: bank -> FULL, index wraps to 0, write bank
//   toggles. FRAME_READY rises the cycle after that write (latency 1).
//  Both banks FULL and DV=1: sample dropped, OVERRUN=1 next cycle; writing resumes into
//   the next bank the cycle after it is released, starting at index 0.
//  Presentation: FRAME_READY=1 whenever any bank is FULL; FRAME_BANK = oldest FULL
//   bank; FRAME_BANK only changes when FRAME_READY=0 or on the cycle after FRAME_DONE.
//  FRAME_DONE with FRAME_READY=1: presented bank -> EMPTY; next cycle FRAME_READY stays
//   1 with FRAME_BANK toggled if other bank FULL, else FRAME_READY=0. FRAME_DONE with
//   FRAME_READY=0 is ignored.
//  Simultaneous: bank becomes FULL in same cycle as FRAME_DONE on the other -> next
//   cycle FRAME_READY=1, FRAME_BANK=newly full bank (no gap).
//  Read: RD_DATA <= mem[FRAME_BANK][RD_ADDR], 1-cycle latency, regardless of
//   FRAME_READY (contents undefined if bank not FULL).
//  Conversion: OFFSET_BIN=1 -> RD value = {~DATA_IN[MSB], DATA_IN[MSB-1:0]};
//   0x0000 -> -8192, 0x2000 -> 0, 0x3FFF -> +8191.
//  OVERRUN_CLR and a new drop in same cycle: OVERRUN stays 1 (set wins).
// STRUCTURE
//  Package fft_pkg: DATA_W, FRAME_LEN, ADDR_W defaults; bank-state enum
//   {BANK_EMPTY, BANK_FILLING, BANK_FULL}; sample_t = signed [DATA_W-1:0].
//  Sub-module frame_ram: simple dual-port RAM, 2*FRAME_LEN x DATA_W, one write port,
//   one registered read port, address {bank, index}; infers iCE40 EBR.
//  Top level holds write counter, bank-state regs, presentation logic, OVERRUN.
// TESTING  (FRAME_LEN=8, OFFSET_BIN=1)
//  1 Reset then 8 DV pulses DATA_IN=0x2000+i -> FRAME_READY=1 one cycle after 8th,
//    FRAME_BANK=0; RD_ADDR=0..7 -> RD_DATA=0..7 one cycle later.
//  2 Conversion: DATA_IN 0x0000/0x2000/0x3FFF -> RD_DATA 0x2000(-8192)/0x0000/0x1FFF.
//  3 Ping-pong: 16 DVs without FRAME_DONE -> FRAME_BANK=0; FRAME_DONE -> next cycle
//    FRAME_READY=1, FRAME_BANK=1, bank-1 data = samples 8..15.
//  4 Overrun: 17 DVs without FRAME_DONE -> 17th dropped, OVERRUN=1; FRAME_DONE then
//    8 DVs -> bank 0 refilled from index 0; OVERRUN_CLR -> OVERRUN=0.
//  5 Simultaneous: 8th DV of bank 1 same cycle as FRAME_DONE for bank 0 -> FRAME_READY
//    held 1, FRAME_BANK=1 next cycle.
//  6 RESET_N low after 5 samples -> all outputs at reset values; next 8 DVs fill bank 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared defaults and types for the ADC frame buffer feeding the FFT core.
package fft_pkg;

  localparam int DATA_W    = 14;
  localparam int FRAME_LEN = 64;
  localparam int ADDR_W    = 6;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_e;

  typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module frame_ram #(
  parameter int DATA_W = 14,
  parameter int AW     = 7
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
  logic [DATA_W-1:0] r_rdata;

  // No reset on the array or read register so the block maps onto EBR.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer: converts DV-qualified ADC samples to signed and hands
// full banks to the FFT core, which reads by address and releases with FRAME_DONE.
module adc_frame_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W     = fft_pkg::DATA_W,
  parameter int FRAME_LEN  = fft_pkg::FRAME_LEN,
  parameter int ADDR_W     = fft_pkg::ADDR_W,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     DV,
  input  logic [DATA_W-1:0]        DATA_IN,
  output logic                     FRAME_READY,
  output logic                     FRAME_BANK,
  input  logic [ADDR_W-1:0]        RD_ADDR,
  output logic signed [DATA_W-1:0] RD_DATA,
  input  logic                     FRAME_DONE,
  output logic                     OVERRUN,
  input  logic                     OVERRUN_CLR
);

  bank_state_e              r_bank_st [2];
  bank_state_e              w_st_nxt  [2];
  logic                     r_wr_bank;
  logic [ADDR_W-1:0]        r_wr_idx;
  logic                     r_pres_bank;
  logic                     r_ovr;
  logic                     r_rd_vld;
  logic                     w_wr_en;
  logic                     w_drop;
  logic                     w_last;
  logic                     w_ready;
  logic                     w_release;
  logic                     w_pres_nxt;
  logic signed [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0]        w_rd_q;

  function automatic logic signed [DATA_W-1:0] conv(input logic [DATA_W-1:0] d);
    if (OFFSET_BIN) return $signed({~d[DATA_W-1], d[DATA_W-2:0]});
    return $signed(d);
  endfunction

  assign w_ready   = (r_bank_st[0] == BANK_FULL) || (r_bank_st[1] == BANK_FULL);
  assign w_wr_en   = DV && (r_bank_st[r_wr_bank] != BANK_FULL);
  // The write bank can only be FULL when both banks are, so this is a true overrun.
  assign w_drop    = DV && (r_bank_st[r_wr_bank] == BANK_FULL);
  assign w_last    = (r_wr_idx == ADDR_W'(FRAME_LEN - 1));
  assign w_release = FRAME_DONE && w_ready;
  assign w_wr_data = conv(DATA_IN);

  // Presented bank stays put while FULL; otherwise it follows the other FULL bank,
  // which keeps it pointing at the oldest full frame.
  always_comb begin
    w_st_nxt[0] = r_bank_st[0];
    w_st_nxt[1] = r_bank_st[1];
    if (w_release) w_st_nxt[r_pres_bank] = BANK_EMPTY;
    if (w_wr_en)   w_st_nxt[r_wr_bank]   = w_last ? BANK_FULL : BANK_FILLING;
    w_pres_nxt = r_pres_bank;
    if ((w_st_nxt[r_pres_bank] != BANK_FULL) && (w_st_nxt[~r_pres_bank] == BANK_FULL))
      w_pres_nxt = ~r_pres_bank;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_bank_st[0] <= BANK_EMPTY;
      r_bank_st[1] <= BANK_EMPTY;
      r_wr_bank    <= 1'b0;
      r_wr_idx     <= '0;
      r_pres_bank  <= 1'b0;
      r_ovr        <= 1'b0;
      r_rd_vld     <= 1'b0;
    end else begin
      r_bank_st[0] <= w_st_nxt[0];
      r_bank_st[1] <= w_st_nxt[1];
      r_pres_bank  <= w_pres_nxt;
      r_rd_vld     <= 1'b1;
      if (w_wr_en) begin
        r_wr_idx <= w_last ? '0 : r_wr_idx + ADDR_W'(1);
        if (w_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_drop)           r_ovr <= 1'b1;
      else if (OVERRUN_CLR) r_ovr <= 1'b0;
    end
  end

  frame_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .i_clk   (CLOCK),
    .i_we    (w_wr_en),
    .i_waddr ({r_wr_bank, r_wr_idx}),
    .i_wdata (w_wr_data),
    .i_raddr ({r_pres_bank, RD_ADDR}),
    .o_rdata (w_rd_q)
  );

  // Read register lives in the RAM; gate it so RD_DATA reads zero out of reset.
  assign RD_DATA     = r_rd_vld ? $signed(w_rd_q) : '0;
  assign FRAME_READY = w_ready;
  assign FRAME_BANK  = r_pres_bank;
  assign OVERRUN     = r_ovr;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Scoreboard bench for adc_frame_buffer with FRAME_LEN=8, offset-binary input.
module tb_adc_frame_buffer;

  localparam int DW = 14;
  localparam int FL = 8;
  localparam int AW = 3;

  logic                 CLOCK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic                 DV = 1'b0;
  logic [DW-1:0]        DATA_IN = '0;
  logic [AW-1:0]        RD_ADDR = '0;
  logic                 FRAME_DONE = 1'b0;
  logic                 OVERRUN_CLR = 1'b0;
  logic                 FRAME_READY;
  logic                 FRAME_BANK;
  logic                 OVERRUN;
  logic signed [DW-1:0] RD_DATA;

  int checks = 0;
  int failures = 0;
  logic signed [DW-1:0] exp_q[$];
  logic signed [DW-1:0] got[FL];
  logic signed [DW-1:0] e;

  always #5 CLOCK = ~CLOCK;

  adc_frame_buffer #(
    .DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW), .OFFSET_BIN(1'b1)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .DV(DV), .DATA_IN(DATA_IN),
    .FRAME_READY(FRAME_READY), .FRAME_BANK(FRAME_BANK), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN),
    .OVERRUN_CLR(OVERRUN_CLR)
  );

  // Offset binary: raw code minus mid-scale, wrapped to DW bits.
  function automatic logic signed [DW-1:0] model_conv(input logic [DW-1:0] raw);
    int v;
    v = int'(raw) - 8192;
    return DW'(v);
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit accept);
    DV = 1'b1;
    DATA_IN = d;
    if (accept) exp_q.push_back(model_conv(d));
    tick();
    DV = 1'b0;
  endtask

  task automatic done_pulse();
    FRAME_DONE = 1'b1;
    tick();
    FRAME_DONE = 1'b0;
  endtask

  task automatic read_frame(output logic signed [DW-1:0] data[FL]);
    for (int a = 0; a < FL; a++) begin
      RD_ADDR = AW'(a);
      tick();
      data[a] = RD_DATA;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #1;
    checks++; if (FRAME_READY !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", FRAME_READY); end
    checks++; if (FRAME_BANK !== 1'b0) begin failures++; $display("FAIL rst_bank got=%b exp=0", FRAME_BANK); end
    checks++; if (RD_DATA !== '0) begin failures++; $display("FAIL rst_rd_data got=%h exp=0", RD_DATA); end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", OVERRUN); end
    tick(); tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < FL - 1; i++) send(DW'(14'h2000 + i), 1'b1);
    checks++; if (FRAME_READY !== 1'b0) begin failures++; $display("FAIL t1_ready_early got=%b exp=0", FRAME_READY); end
    send(DW'(14'h2000 + FL - 1), 1'b1);
    checks++; if (FRAME_READY !== 1'b1) begin failures++; $display("FAIL t1_ready got=%b exp=1", FRAME_READY); end
    checks++; if (FRAME_BANK !== 1'b0) begin failures++; $display("FAIL t1_bank got=%b exp=0", FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t1_data[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
    checks++; if (FRAME_READY !== 1'b0) begin failures++; $display("FAIL t1_release got=%b exp=0", FRAME_READY); end
  endtask

  task automatic test_conversion();
    logic [DW-1:0] raw[FL];
    raw = '{14'h0000, 14'h2000, 14'h3FFF, 14'h1FFF, 14'h2001, 14'h0001, 14'h3FFE, 14'h1234};
    for (int i = 0; i < FL; i++) send(raw[i], 1'b1);
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b1) begin
      failures++; $display("FAIL t2_present got=%b/%b exp=1/1", FRAME_READY, FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t2_conv[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
  endtask

  task automatic test_ping_pong();
    for (int i = 0; i < 2 * FL; i++) send(DW'($urandom_range(0, 16383)), 1'b1);
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b0) begin
      failures++; $display("FAIL t3_first got=%b/%b exp=1/0", FRAME_READY, FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t3_bank0[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b1) begin
      failures++; $display("FAIL t3_toggle got=%b/%b exp=1/1", FRAME_READY, FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t3_bank1[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
    checks++; if (FRAME_READY !== 1'b0) begin failures++; $display("FAIL t3_empty got=%b exp=0", FRAME_READY); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 2 * FL; i++) send(DW'(14'h0100 + i), 1'b1);
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL t4_no_ovr got=%b exp=0", OVERRUN); end
    send(14'h3333, 1'b0);
    checks++; if (OVERRUN !== 1'b1) begin failures++; $display("FAIL t4_ovr got=%b exp=1", OVERRUN); end
    OVERRUN_CLR = 1'b1;
    send(14'h3334, 1'b0);
    OVERRUN_CLR = 1'b0;
    checks++; if (OVERRUN !== 1'b1) begin failures++; $display("FAIL t4_set_wins got=%b exp=1", OVERRUN); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t4_bank0[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b1) begin
      failures++; $display("FAIL t4_present1 got=%b/%b exp=1/1", FRAME_READY, FRAME_BANK); end
    for (int i = 0; i < FL; i++) send(DW'(14'h0A00 + i), 1'b1);
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t4_bank1[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b0) begin
      failures++; $display("FAIL t4_refill got=%b/%b exp=1/0", FRAME_READY, FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t4_refill[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL t4_clr got=%b exp=0", OVERRUN); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < FL; i++) send(DW'(14'h1100 + i), 1'b1);
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t5_prefill[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
    for (int i = 0; i < 2 * FL - 1; i++) send(DW'(14'h2200 + i), 1'b1);
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b0) begin
      failures++; $display("FAIL t5_bank0 got=%b/%b exp=1/0", FRAME_READY, FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t5_b0data[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    FRAME_DONE = 1'b1;
    send(DW'(14'h2200 + 2 * FL - 1), 1'b1);
    FRAME_DONE = 1'b0;
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b1) begin
      failures++; $display("FAIL t5_nogap got=%b/%b exp=1/1", FRAME_READY, FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t5_b1data[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
    done_pulse();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send(DW'(14'h0F00 + i), 1'b1);
    exp_q.delete();
    RESET_N = 1'b0;
    #1;
    checks++; if (FRAME_READY !== 1'b0) begin failures++; $display("FAIL t6_ready got=%b exp=0", FRAME_READY); end
    checks++; if (FRAME_BANK !== 1'b0) begin failures++; $display("FAIL t6_bank got=%b exp=0", FRAME_BANK); end
    checks++; if (RD_DATA !== '0) begin failures++; $display("FAIL t6_rd_data got=%h exp=0", RD_DATA); end
    checks++; if (OVERRUN !== 1'b0) begin failures++; $display("FAIL t6_overrun got=%b exp=0", OVERRUN); end
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    for (int i = 0; i < FL - 1; i++) send(DW'(14'h3000 + i), 1'b1);
    checks++; if (FRAME_READY !== 1'b0) begin failures++; $display("FAIL t6_early got=%b exp=0", FRAME_READY); end
    send(DW'(14'h3000 + FL - 1), 1'b1);
    checks++; if (FRAME_READY !== 1'b1 || FRAME_BANK !== 1'b0) begin
      failures++; $display("FAIL t6_full got=%b/%b exp=1/0", FRAME_READY, FRAME_BANK); end
    read_frame(got);
    for (int i = 0; i < FL; i++) begin
      checks++; e = exp_q.pop_front();
      if (got[i] !== e) begin failures++; $display("FAIL t6_data[%0d] got=%0d exp=%0d", i, got[i], e); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_conversion();
    test_ping_pong();
    test_overrun();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
